// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction-cache and data-cache line requests
// onto a single line-wide memory port, with instruction-fill abort support.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_abort,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate eligible requests
  // I_BUSY | instruction fill in flight on memory port
  // D_BUSY | data fill or writeback in flight on memory port
  // I_DROP | aborted instruction fill; wait out memory, discard data
  // RESP   | one-cycle ready pulse to the served requester
  typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_DROP, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              i_hold_q, i_hold_d;
  logic              d_hold_q, d_hold_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_elig, d_elig;

  // A served requester is ignored until it drops its request, so a request
  // still held across RESP is never granted twice.
  assign i_elig = i_req & ~i_abort & ~i_hold_q;
  assign d_elig = d_req & ~d_hold_q;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    i_hold_d    = i_hold_q & i_req;
    d_hold_d    = d_hold_q & d_req;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (i_elig && (!d_elig || last_d_q)) begin
          state_d    = I_BUSY;
          last_d_d   = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {i_addr[ADDR_W-1:6], 6'b0};
        end else if (d_elig) begin
          state_d     = D_BUSY;
          last_d_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = {d_addr[ADDR_W-1:6], 6'b0};
          mem_wdata_d = d_wdata;
        end
      end
      I_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          // Abort coinciding with completion: the data is simply discarded.
          if (i_abort) begin
            state_d = IDLE;
          end else begin
            state_d   = RESP;
            i_ready_d = 1'b1;
            i_hold_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (i_abort) begin
          state_d = I_DROP;
        end
      end
      D_BUSY: begin
        if (mem_ready) begin
          state_d   = RESP;
          d_ready_d = 1'b1;
          d_hold_d  = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
      I_DROP: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      i_hold_q    <= 1'b0;
      d_hold_q    <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      i_hold_q    <= i_hold_d;
      d_hold_q    <= d_hold_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width.
REQ-002 Parameter: LINE_W, default 512, cache-line width in bits (16 words).
REQ-003 The block SHALL have ports (name  direction  width  meaning):
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- i_req  input  1  instruction-cache line-fill request; held until i_ready or abort.
- i_addr  input  ADDR_W  instruction fill address.
- i_abort  input  1  cancel the instruction fill (branch/jump redirect).
- i_ready  output  1  one-cycle pulse: i_rdata valid.
- i_rdata  output  LINE_W  returned instruction line.
- d_req  input  1  data-cache request; held until d_ready.
- d_we  input  1  1 = line writeback, 0 = line fill.
- d_addr  input  ADDR_W  data request address.
- d_wdata  input  LINE_W  writeback line.
- d_ready  output  1  one-cycle pulse: fill data valid or writeback done.
- d_rdata  output  LINE_W  returned data line.
- mem_req  output  1  memory transaction active.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  line-aligned memory address.
- mem_wdata  output  LINE_W  memory write line.
- mem_ready  input  1  memory completion pulse; mem_rdata valid when mem_we=0.
- mem_rdata  input  LINE_W  memory read line.

Function
REQ-004 The block SHALL implement FSM states IDLE, I_BUSY, D_BUSY, I_DROP, RESP.
REQ-005 In IDLE, when exactly one of (i_req & !i_abort) or d_req is high, the block SHALL grant that requester at the next edge (IDLE -> I_BUSY or D_BUSY).
REQ-006 When both are eligible in IDLE, the block SHALL grant the requester not granted last (round-robin); last_grant updates on every grant.
REQ-007 At grant the block SHALL latch the address as {addr[ADDR_W-1:6], 6'b0}, plus d_we and d_wdata for D; later input changes SHALL be ignored until the transaction ends.
REQ-008 mem_req SHALL be 1 in I_BUSY, D_BUSY and I_DROP and 0 otherwise; mem_we = latched d_we in D_BUSY, else 0; mem_addr/mem_wdata SHALL stay constant while mem_req=1.
REQ-009 In I_BUSY or D_BUSY with mem_ready=1, the block SHALL capture mem_rdata into i_rdata (I) or, on a D fill, into d_rdata, and move to RESP; a D writeback SHALL leave d_rdata unchanged.
REQ-010 In RESP the block SHALL assert exactly one of i_ready/d_ready for one cycle, then return to IDLE; no grant is evaluated in RESP.
REQ-011 Latency: request seen in IDLE at edge n, mem_req high from n; mem_ready seen at edge m -> ready high during cycle after m; minimum request-to-ready = 2 cycles plus memory latency.
REQ-012 i_abort=1 in I_BUSY SHALL move to I_DROP; I_DROP SHALL hold mem_req until mem_ready, then go to IDLE with no i_ready pulse and i_rdata unchanged.
REQ-013 i_abort=1 in the same IDLE cycle as i_req SHALL suppress the I grant; d_req may be granted that cycle.
REQ-014 i_abort SHALL have no effect in D_BUSY, RESP or I_DROP.
REQ-015 mem_ready while mem_req=0 SHALL be ignored.
REQ-016 i_rdata/d_rdata SHALL hold their value until next overwritten per REQ-009.
REQ-017 All outputs SHALL be driven from registers (no combinational input-to-output path).

Reset
REQ-018 While reset=1: state=IDLE, last_grant=I (so D wins the first tie), all outputs 0 including i_rdata/d_rdata and mem_addr.
REQ-019 reset asserted mid-transaction SHALL abandon it immediately; no ready pulse SHALL follow deassertion.

Verification
REQ-020 I fill alone: i_addr=0x0000_0044, memory ready after 20 cycles -> mem_addr=0x0000_0040, mem_we=0, i_ready one pulse, i_rdata=memory line.
REQ-021 Tie after reset: i_req and d_req same cycle -> D granted first, then I; second tie -> D again only if last grant was I.
REQ-022 Writeback: d_we=1, d_addr=0x0000_1080, d_wdata=pattern A -> mem_we=1, mem_addr=0x0000_1080, mem_wdata=A, d_ready pulse, d_rdata unchanged.
REQ-023 Abort: i_abort at cycle 5 of I fill -> mem_req held to mem_ready, no i_ready, pending d_req granted next IDLE cycle.
REQ-024 Reset at cycle 10 of D fill -> all outputs 0, IDLE, no d_ready after release.
REQ-025 Back-to-back: i_req held over RESP -> no double grant; new grant only after requester drops and re-raises i_req.
